multicycle_ctrl_fsm: RTL

Main control unit for the multicycle MIPS datapath, successor to `control_module`. It decodes a parametrised-width `Op_code` into per-state datapath controls. Beyond the previous opcode set, it adds BNE, ADDI and JAL, a memory wait handshake (`mem_ready`) for variable-latency memory, a sticky illegal-opcode flag, and a debug state output. It sits between the instruction register and the datapath mux/enable inputs.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 68 ++++++
 rtl/ctrl_output_decode.sv | 82 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 110 +++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, state encoding,
// datapath select codes and the bundled control-output struct.
package multicycle_ctrl_fsm_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StJal      = 4'd10,
    StAddiExec = 4'd11,
    StAddiWb   = 4'd12
  } state_e;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] M2rAluOut = 2'd0;
  localparam logic [1:0] M2rMdr    = 2'd1;
  localparam logic [1:0] M2rPc     = 2'd2;

  localparam logic [2:0] SrcBReg    = 3'd0;
  localparam logic [2:0] SrcBFour   = 3'd1;
  localparam logic [2:0] SrcBImm    = 3'd2;
  localparam logic [2:0] SrcBImmSh2 = 3'd3;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       branch_ne;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: current state (plus mem_ready and the latched BNE flag) to
// datapath controls. Everything is zero while i_en is low.
module ctrl_output_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_ready,
  input  logic   i_is_bne,
  input  logic   i_en,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    if (i_en) begin
      case (i_state)
        StFetch: begin
          o_ctrl.mem_read  = 1'b1;
          o_ctrl.alu_src_b = SrcBFour;
          o_ctrl.alu_op    = AluAdd;
          o_ctrl.pc_source = PcSrcAlu;
          o_ctrl.ir_write  = i_mem_ready;
          o_ctrl.pc_write  = i_mem_ready;
        end
        StDecode: o_ctrl.alu_src_b = SrcBImmSh2;
        StMemAddr, StAddiExec: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SrcBImm;
        end
        StMemRead: begin
          o_ctrl.mem_read = 1'b1;
          o_ctrl.i_or_d   = 1'b1;
        end
        StMemWb: begin
          o_ctrl.reg_dst    = RegDstRt;
          o_ctrl.mem_to_reg = M2rMdr;
          o_ctrl.reg_write  = 1'b1;
        end
        StMemWrite: begin
          o_ctrl.mem_write = 1'b1;
          o_ctrl.i_or_d    = 1'b1;
        end
        StExecute: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SrcBReg;
          o_ctrl.alu_op    = AluFunct;
        end
        StRWb: begin
          o_ctrl.reg_dst    = RegDstRd;
          o_ctrl.mem_to_reg = M2rAluOut;
          o_ctrl.reg_write  = 1'b1;
        end
        StBranch: begin
          o_ctrl.alu_src_a     = 1'b1;
          o_ctrl.alu_op        = AluSub;
          o_ctrl.pc_write_cond = 1'b1;
          o_ctrl.pc_source     = PcSrcAluOut;
          o_ctrl.branch_ne     = i_is_bne;
        end
        StJump: begin
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PcSrcJump;
        end
        // PC already holds PC+4 from FETCH, so it is the link value written to $31.
        StJal: begin
          o_ctrl.pc_write   = 1'b1;
          o_ctrl.pc_source  = PcSrcJump;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = RegDstRa;
          o_ctrl.mem_to_reg = M2rPc;
        end
        StAddiWb: begin
          o_ctrl.reg_dst    = RegDstRt;
          o_ctrl.mem_to_reg = M2rAluOut;
          o_ctrl.reg_write  = 1'b1;
        end
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS main control: state register, next-state logic and the sticky
// illegal-opcode flag; output decoding lives in ctrl_output_decode.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned SRCB_W = 3,
  parameter int unsigned ST_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   Op_code,
  input  logic              mem_ready,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic              PCWriteCond,
  output logic              PCWrite,
  output logic              IorD,
  output logic              MemRead,
  output logic              BranchNe,
  output logic [1:0]        RegDst,
  output logic [1:0]        MemtoReg,
  output logic [SRCB_W-1:0] ALUSrcB,
  output logic [1:0]        ALUOp,
  output logic [1:0]        PCSource,
  output logic              illegal_op,
  output logic [ST_W-1:0]   state
);

  state_e r_state, w_state_d;
  logic   r_illegal, w_illegal_d;
  logic   r_is_sw, w_is_sw_d;
  logic   r_is_bne, w_is_bne_d;
  ctrl_t  w_ctrl;

  always_comb begin
    w_state_d   = r_state;
    w_illegal_d = r_illegal;
    w_is_sw_d   = r_is_sw;
    w_is_bne_d  = r_is_bne;
    case (r_state)
      StFetch: if (mem_ready) w_state_d = StDecode;
      // Opcode is only valid here; remember what later states still need.
      StDecode: begin
        w_is_sw_d  = (Op_code == OP_W'(OpSw));
        w_is_bne_d = (Op_code == OP_W'(OpBne));
        case (Op_code)
          OP_W'(OpLw), OP_W'(OpSw):   w_state_d = StMemAddr;
          OP_W'(OpRtype):             w_state_d = StExecute;
          OP_W'(OpBeq), OP_W'(OpBne): w_state_d = StBranch;
          OP_W'(OpJ):                 w_state_d = StJump;
          OP_W'(OpJal):               w_state_d = StJal;
          OP_W'(OpAddi):              w_state_d = StAddiExec;
          default: begin
            w_state_d   = StFetch;
            w_illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr:  w_state_d = r_is_sw ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) w_state_d = StMemWb;
      StMemWrite: if (mem_ready) w_state_d = StFetch;
      StExecute:  w_state_d = StRWb;
      StAddiExec: w_state_d = StAddiWb;
      default:    w_state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
      r_is_sw   <= 1'b0;
      r_is_bne  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_illegal <= w_illegal_d;
      r_is_sw   <= w_is_sw_d;
      r_is_bne  <= w_is_bne_d;
    end
  end

  ctrl_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_is_bne    (r_is_bne),
    .i_en        (rst),
    .o_ctrl      (w_ctrl)
  );

  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign PCWrite     = w_ctrl.pc_write;
  assign IorD        = w_ctrl.i_or_d;
  assign MemRead     = w_ctrl.mem_read;
  assign BranchNe    = w_ctrl.branch_ne;
  assign RegDst      = w_ctrl.reg_dst;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign ALUSrcB     = SRCB_W'(w_ctrl.alu_src_b);
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign illegal_op  = rst & r_illegal;
  assign state       = rst ? ST_W'(r_state) : '0;

endmodule
